uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver that consumes the UART line driven by the transmitter. It takes a frame of 1 start bit, 8 data bits LSB first, an optional parity bit and 1 stop bit, each held for `PRESCALE` clocks, and recovers it into a parallel byte. It reports the byte with a one-cycle valid pulse, and pulses error flags for bad parity or a bad stop bit. It sits directly after the TX line, or after an external loopback of it, and uses the same frame format and parity convention as the TX.

## Interface
- `PRESCALE`, default 8: clocks per bit. Must be even and ≥ 4.
- `clk`  in  1: single clock.
- `reset`  in  1: asynchronous reset, active-high.
- `RX_IN`  in  1: serial line, idle high. Asynchronous to `clk`.
- `PAR_EN`  in  1: a parity bit is expected after the data bits.
- `PAR_TYP`  in  1: parity type. 0 means the expected bit is `~^data` (odd). 1 means the expected bit is `^data` (even).
- `P_DATA`  out  8: last good received byte.
- `DATA_VALID`  out  1: one-cycle pulse when a good byte is available on `P_DATA`.
- `PAR_ERR`  out  1: one-cycle pulse when the parity bit mismatches.
- `STP_ERR`  out  1: one-cycle pulse when the stop bit is sampled 0.
- `RX_BUSY`  out  1: high whenever the FSM is not in IDLE.

## Operation
- `RX_IN` passes through a 2-flop synchronizer, giving `rx_s`. Both flops reset to 1.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- A bit counter `cnt` runs 0..`PRESCALE-1`. Bit index `idx` runs 0..7.
- `armed` flag: set whenever `rx_s` = 1 in IDLE.
- IDLE → START when `rx_s` = 0 and `armed` = 1. On this edge:
  - `cnt` ← 0.
  - `PAR_EN` and `PAR_TYP` are latched for the whole frame. Mid-frame changes are ignored.
- Bit value sampling:
  - A bit value is taken when `cnt` = `PRESCALE/2`.
  - A bit ends when `cnt` = `PRESCALE-1`; `cnt` then wraps to 0.
- START:
  - If the mid sample is 1, this is a false start: go to IDLE with no output pulses.
  - Otherwise go to DATA at the end of the bit.
- DATA: the sample is stored into `shift[idx]`. After `idx` = 7 ends, go to PARITY if `PAR_EN` is set, else go to STOP.
- PARITY: compare the sample with the expected bit per the latched `PAR_TYP`. Record a mismatch internally.
- STOP: at the mid sample, go directly to IDLE (half a bit early, for resync). Exactly one of these outcomes, registered:
  - Stop = 1 and no parity mismatch: `P_DATA` ← `shift`, `DATA_VALID` = 1.
  - Stop = 1 and parity mismatch: `PAR_ERR` = 1. `P_DATA` is unchanged.
  - Stop = 0: `STP_ERR` = 1. `PAR_ERR` is also pulsed if there was a mismatch. `armed` is cleared, so a held-low line (break) does not retrigger.
- `DATA_VALID` and the error flags are never high together with each other except `PAR_ERR` with `STP_ERR`.

## Timing
- Reset values: `P_DATA` = 0, `DATA_VALID` = `PAR_ERR` = `STP_ERR` = `RX_BUSY` = 0, state = IDLE, `armed` = 1.
- Reset mid-frame discards the partial byte. No pulse is emitted.
- Define edge 0 as the first `clk` edge at which `RX_IN` is low. N = 9 without parity, 10 with parity.
- The result pulse is high for exactly the cycle after edge N·`PRESCALE` + `PRESCALE/2` + 3.
- `RX_BUSY` rises after edge 2 and falls together with the result pulse.
- Back-to-back frames: a start bit immediately following the stop bit is detected with no lost frame.
- No flow control. A byte not consumed is overwritten by the next one.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each bit is the 2-of-3 majority of samples at `cnt` = `PRESCALE/2-1`, `PRESCALE/2`, `PRESCALE/2+1`.
  - The decision edge moves one clock later, so the result-pulse latency becomes +1 (… + 4).
  - The start check also uses the majority value.
- Not defined: a single sample at `PRESCALE/2`, with the latency as given in Timing.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP), shared with the TX and its golden model;
  - the frame constant `DATA_BITS` = 8;
  - a `parity_calc(data, typ)` function used by both TX and RX.
- One sub-module, `uart_rx_sampler`. It contains the synchronizer, the `cnt` counter and the single/majority sample logic, and outputs `bit_val`, `sample_stb` and `bit_end`.
- The FSM, shift register and output registers stay in `uart_rx`.

## Test plan
- `PAR_EN`=0, `PRESCALE`=8, frame for 0xA5 → `P_DATA`=0xA5, `DATA_VALID` high for exactly 1 cycle after edge 79, no error flags.
- `PAR_EN`=1, `PAR_TYP`=0, 0x3C with parity bit 1 → `DATA_VALID`, `P_DATA`=0x3C. The same frame with parity bit 0 → `PAR_ERR` pulse, `P_DATA` unchanged.
- 0x81 with stop bit 0, then line held low for 30 bits, then high, then a 0x55 frame → one `STP_ERR` only, no retrigger during the low period, then `DATA_VALID` with 0x55.
- Low glitch of 2 clocks on an idle line → no output pulse, `RX_BUSY` returns to 0 by edge 7. With `UART_RX_MAJORITY_EN`, a 1-clock mid-bit glitch inside a data bit of 0xFF still yields 0xFF.
- `reset` asserted during data bit 4 of frame 0x12, then a clean 0x34 frame → no pulse for 0x12, `DATA_VALID` with 0x34.
- Loopback from the TX at `PRESCALE`=1-equivalent timing, using 20 random bytes with random `PAR_EN`/`PAR_TYP`, stretched ×8 → every byte received, no error flags.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame definitions used by TX, RX and their models
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

   // typ = 1: even parity bit (^data); typ = 0: odd parity bit (~^data)
   function automatic logic parity_calc(input logic [DATA_BITS-1:0] data, input logic typ);
      return typ ? ^data : ~^data;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - RX line synchronizer, bit-period counter and bit sampler
// UART_RX_MAJORITY_EN selects a 2-of-3 majority sample around mid-bit.
module uart_rx_sampler #(
   parameter int PRESCALE = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic rx_in,
   input  logic cnt_clr,
   output logic rx_s,
   output logic bit_val,
   output logic sample_stb,
   output logic bit_end
);

   localparam int CW = $clog2(PRESCALE);
   localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

   logic          sync1_q, sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= rx_in;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_clr || cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   localparam logic [CW-1:0] CNT_STB = CW'(PRESCALE / 2 + 1);

   // Two previous synchronized samples; at CNT_STB they hold mid-1 and mid.
   logic [1:0] hist_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= {hist_q[0], sync2_q};
      end
   end

   assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync2_q) | (hist_q[0] & sync2_q);
`else
   localparam logic [CW-1:0] CNT_STB = CW'(PRESCALE / 2);

   assign bit_val = sync2_q;
`endif

   assign rx_s       = sync2_q;
   assign sample_stb = (cnt_q == CNT_STB);
   assign bit_end    = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: frame FSM, shift register and result pulses
// Optional UART_RX_MAJORITY_EN is handled inside uart_rx_sampler.
module uart_rx
   import uart_pkg::*;
#(
   parameter int PRESCALE = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       RX_IN,
   input  logic       PAR_EN,
   input  logic       PAR_TYP,
   output logic [7:0] P_DATA,
   output logic       DATA_VALID,
   output logic       PAR_ERR,
   output logic       STP_ERR,
   output logic       RX_BUSY
);

   uart_state_e           state_q, state_d;
   logic [2:0]            idx_q, idx_d;
   logic [DATA_BITS-1:0]  shift_q, shift_d;
   logic [DATA_BITS-1:0]  pdata_q, pdata_d;
   logic                  armed_q, armed_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic                  perr_q, perr_d;
   logic                  valid_q, valid_d;
   logic                  par_err_q, par_err_d;
   logic                  stp_err_q, stp_err_d;

   logic rx_s, bit_val, sample_stb, bit_end;

   uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
      .clk        (clk),
      .reset      (reset),
      .rx_in      (RX_IN),
      .cnt_clr    (state_q == IDLE),
      .rx_s       (rx_s),
      .bit_val    (bit_val),
      .sample_stb (sample_stb),
      .bit_end    (bit_end)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         shift_q   <= '0;
         pdata_q   <= '0;
         armed_q   <= 1'b1;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         perr_q    <= 1'b0;
         valid_q   <= 1'b0;
         par_err_q <= 1'b0;
         stp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         pdata_q   <= pdata_d;
         armed_q   <= armed_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         perr_q    <= perr_d;
         valid_q   <= valid_d;
         par_err_q <= par_err_d;
         stp_err_q <= stp_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      pdata_d   = pdata_q;
      armed_d   = armed_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      perr_d    = perr_q;
      valid_d   = 1'b0;
      par_err_d = 1'b0;
      stp_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (rx_s) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               state_d   = START;
               idx_d     = '0;
               perr_d    = 1'b0;
               par_en_d  = PAR_EN;
               par_typ_d = PAR_TYP;
            end
         end
         START: begin
            if (sample_stb && bit_val) begin
               state_d = IDLE;
            end else if (bit_end) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (sample_stb) begin
               shift_d[idx_q] = bit_val;
            end
            if (bit_end) begin
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'(DATA_BITS - 1)) begin
                  state_d = par_en_q ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            if (sample_stb && (bit_val != parity_calc(shift_q, par_typ_q))) begin
               perr_d = 1'b1;
            end
            if (bit_end) begin
               state_d = STOP;
            end
         end
         STOP: begin
            // Leave at mid stop bit so the next start edge is seen on time.
            if (sample_stb) begin
               state_d = IDLE;
               if (bit_val) begin
                  if (perr_q) begin
                     par_err_d = 1'b1;
                  end else begin
                     valid_d = 1'b1;
                     pdata_d = shift_q;
                  end
               end else begin
                  stp_err_d = 1'b1;
                  par_err_d = perr_q;
                  armed_d   = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign P_DATA     = pdata_q;
   assign DATA_VALID = valid_q;
   assign PAR_ERR    = par_err_q;
   assign STP_ERR    = stp_err_q;
   assign RX_BUSY    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a frame-level reference model
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int P = 8;
`ifdef UART_RX_MAJORITY_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       RX_IN = 1'b1;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [7:0] P_DATA;
   logic       DATA_VALID, PAR_ERR, STP_ERR, RX_BUSY;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   int         vq_cyc[$];
   logic [7:0] vq_dat[$];
   int         pq_cyc[$];
   int         sq_cyc[$];
   int         busy_rises = 0;
   int         last_rise = -1;
   int         last_fall = -1;
   logic       busy_prev = 1'b0;

   uart_rx #(.PRESCALE(P)) dut (
      .clk        (clk),
      .reset      (reset),
      .RX_IN      (RX_IN),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_ERR    (PAR_ERR),
      .STP_ERR    (STP_ERR),
      .RX_BUSY    (RX_BUSY)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse recorder: cyc equals the number of the edge just before this negedge.
   always @(negedge clk) begin
      if (DATA_VALID) begin
         vq_cyc.push_back(cyc);
         vq_dat.push_back(P_DATA);
      end
      if (PAR_ERR) pq_cyc.push_back(cyc);
      if (STP_ERR) sq_cyc.push_back(cyc);
      if (DATA_VALID && (PAR_ERR || STP_ERR)) begin
         failures++;
         $display("FAIL exclusive_flags at edge %0d: valid=%b par=%b stp=%b, valid must be alone", cyc, DATA_VALID, PAR_ERR, STP_ERR);
      end
      if (RX_BUSY && !busy_prev) begin
         busy_rises++;
         last_rise = cyc;
      end
      if (!RX_BUSY && busy_prev) last_fall = cyc;
      busy_prev = RX_BUSY;
   end

   function automatic int res_cyc(input int e0, input logic pe);
      return e0 + (pe ? 10 : 9) * P + P / 2 + 3 + EXTRA;
   endfunction

   function automatic logic exp_par(input logic [7:0] d, input logic typ);
      int ones;
      ones = $countones(d);
      return 1'((ones + (typ ? 0 : 1)) % 2);
   endfunction

   task automatic clear_mon;
      vq_cyc.delete();
      vq_dat.delete();
      pq_cyc.delete();
      sq_cyc.delete();
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Starts 1 time unit after a posedge; the next edge is edge 0 of the frame.
   task automatic send_frame(input logic [7:0] d, input logic pe, input logic typ,
                             input logic pbit, input logic sbit, output int e0);
      PAR_EN  = pe;
      PAR_TYP = typ;
      RX_IN   = 1'b0;
      e0      = cyc + 1;
      hold(P);
      PAR_EN  = 1'($urandom);
      PAR_TYP = 1'($urandom);
      for (int i = 0; i < 8; i++) begin
         RX_IN = d[i];
         hold(P);
      end
      if (pe) begin
         RX_IN = pbit;
         hold(P);
      end
      RX_IN = sbit;
      hold(P);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (P_DATA !== 8'h00) begin failures++; $display("FAIL reset_pdata got=%h exp=00", P_DATA); end
      checks++; if (DATA_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", DATA_VALID); end
      checks++; if (PAR_ERR !== 1'b0) begin failures++; $display("FAIL reset_par_err got=%b exp=0", PAR_ERR); end
      checks++; if (STP_ERR !== 1'b0) begin failures++; $display("FAIL reset_stp_err got=%b exp=0", STP_ERR); end
      checks++; if (RX_BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", RX_BUSY); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      hold(4);
      checks++; if (RX_BUSY !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", RX_BUSY); end
   endtask

   task automatic test_basic;
      int e0, exp_c;
      clear_mon();
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, e0);
      hold(2 * P);
      exp_c = res_cyc(e0, 1'b0);
      checks++;
      if (vq_cyc.size() != 1) begin
         failures++; $display("FAIL basic_valid_count got=%0d exp=1", vq_cyc.size());
      end else begin
         checks++; if (vq_cyc[0] != exp_c) begin failures++; $display("FAIL basic_valid_edge got=%0d exp=%0d", vq_cyc[0] - e0, exp_c - e0); end
         checks++; if (vq_dat[0] !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", vq_dat[0]); end
      end
      checks++; if (pq_cyc.size() + sq_cyc.size() != 0) begin failures++; $display("FAIL basic_err_flags got=%0d exp=0", pq_cyc.size() + sq_cyc.size()); end
      checks++; if (last_rise != e0 + 2) begin failures++; $display("FAIL basic_busy_rise got=%0d exp=2", last_rise - e0); end
      checks++; if (last_fall != exp_c) begin failures++; $display("FAIL basic_busy_fall got=%0d exp=%0d", last_fall - e0, exp_c - e0); end
   endtask

   task automatic test_parity;
      int ea, eb;
      clear_mon();
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, ea);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, eb);
      hold(2 * P);
      checks++;
      if (vq_cyc.size() != 1) begin
         failures++; $display("FAIL par_valid_count got=%0d exp=1", vq_cyc.size());
      end else begin
         checks++; if (vq_dat[0] !== 8'h3C) begin failures++; $display("FAIL par_data got=%h exp=3c", vq_dat[0]); end
         checks++; if (vq_cyc[0] != res_cyc(ea, 1'b1)) begin failures++; $display("FAIL par_valid_edge got=%0d exp=%0d", vq_cyc[0] - ea, res_cyc(ea, 1'b1) - ea); end
      end
      checks++;
      if (pq_cyc.size() != 1) begin
         failures++; $display("FAIL par_err_count got=%0d exp=1", pq_cyc.size());
      end else begin
         checks++; if (pq_cyc[0] != res_cyc(eb, 1'b1)) begin failures++; $display("FAIL par_err_edge got=%0d exp=%0d", pq_cyc[0] - eb, res_cyc(eb, 1'b1) - eb); end
      end
      checks++; if (sq_cyc.size() != 0) begin failures++; $display("FAIL par_stp_count got=%0d exp=0", sq_cyc.size()); end
      checks++; if (P_DATA !== 8'h3C) begin failures++; $display("FAIL par_pdata_kept got=%h exp=3c", P_DATA); end
   endtask

   task automatic test_break;
      int e0, e1, rises0;
      clear_mon();
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, e0);
      rises0 = busy_rises;
      hold(30 * P);
      checks++; if (busy_rises != rises0) begin failures++; $display("FAIL break_retrigger got=%0d exp=0", busy_rises - rises0); end
      RX_IN = 1'b1;
      hold(2 * P);
      send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b1, e1);
      hold(2 * P);
      checks++;
      if (sq_cyc.size() != 1) begin
         failures++; $display("FAIL break_stp_count got=%0d exp=1", sq_cyc.size());
      end else begin
         checks++; if (sq_cyc[0] != res_cyc(e0, 1'b0)) begin failures++; $display("FAIL break_stp_edge got=%0d exp=%0d", sq_cyc[0] - e0, res_cyc(e0, 1'b0) - e0); end
      end
      checks++; if (pq_cyc.size() != 0) begin failures++; $display("FAIL break_par_count got=%0d exp=0", pq_cyc.size()); end
      checks++;
      if (vq_cyc.size() != 1) begin
         failures++; $display("FAIL break_valid_count got=%0d exp=1", vq_cyc.size());
      end else begin
         checks++; if (vq_dat[0] !== 8'h55) begin failures++; $display("FAIL break_data got=%h exp=55", vq_dat[0]); end
         checks++; if (vq_cyc[0] != res_cyc(e1, 1'b0)) begin failures++; $display("FAIL break_valid_edge got=%0d exp=%0d", vq_cyc[0] - e1, res_cyc(e1, 1'b0) - e1); end
      end
   endtask

   task automatic test_glitch;
      int e0;
      clear_mon();
      RX_IN = 1'b0;
      e0 = cyc + 1;
      hold(2);
      RX_IN = 1'b1;
      while (cyc < e0 + 6 + EXTRA) @(negedge clk);
      checks++; if (RX_BUSY !== 1'b1) begin failures++; $display("FAIL glitch_busy_mid got=%b exp=1", RX_BUSY); end
      @(negedge clk);
      checks++; if (RX_BUSY !== 1'b0) begin failures++; $display("FAIL glitch_busy_end got=%b exp=0", RX_BUSY); end
      @(posedge clk);
      #1;
      hold(3 * P);
      checks++; if (vq_cyc.size() + pq_cyc.size() + sq_cyc.size() != 0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=0", vq_cyc.size() + pq_cyc.size() + sq_cyc.size()); end
   endtask

`ifdef UART_RX_MAJORITY_EN
   task automatic test_majority_glitch;
      clear_mon();
      PAR_EN = 1'b0;
      RX_IN  = 1'b0;
      hold(P);
      for (int i = 0; i < 8; i++) begin
         RX_IN = 1'b1;
         if (i == 3) begin
            hold(P / 2 + 1);
            RX_IN = 1'b0;
            hold(1);
            RX_IN = 1'b1;
            hold(P / 2 - 2);
         end else begin
            hold(P);
         end
      end
      RX_IN = 1'b1;
      hold(3 * P);
      checks++;
      if (vq_cyc.size() != 1) begin
         failures++; $display("FAIL maj_valid_count got=%0d exp=1", vq_cyc.size());
      end else begin
         checks++; if (vq_dat[0] !== 8'hFF) begin failures++; $display("FAIL maj_data got=%h exp=ff", vq_dat[0]); end
      end
   endtask
`endif

   task automatic test_reset_mid;
      int e1;
      logic [7:0] d;
      d = 8'h12;
      clear_mon();
      PAR_EN = 1'b0;
      RX_IN  = 1'b0;
      hold(P);
      for (int i = 0; i < 4; i++) begin
         RX_IN = d[i];
         hold(P);
      end
      RX_IN = d[4];
      hold(P / 2);
      reset = 1'b1;
      RX_IN = 1'b1;
      @(negedge clk);
      checks++; if (RX_BUSY !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", RX_BUSY); end
      checks++; if (P_DATA !== 8'h00) begin failures++; $display("FAIL rmid_pdata got=%h exp=00", P_DATA); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      hold(2 * P);
      send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, e1);
      hold(2 * P);
      checks++;
      if (vq_cyc.size() != 1) begin
         failures++; $display("FAIL rmid_valid_count got=%0d exp=1", vq_cyc.size());
      end else begin
         checks++; if (vq_dat[0] !== 8'h34) begin failures++; $display("FAIL rmid_data got=%h exp=34", vq_dat[0]); end
         checks++; if (vq_cyc[0] != res_cyc(e1, 1'b0)) begin failures++; $display("FAIL rmid_valid_edge got=%0d exp=%0d", vq_cyc[0] - e1, res_cyc(e1, 1'b0) - e1); end
      end
      checks++; if (pq_cyc.size() + sq_cyc.size() != 0) begin failures++; $display("FAIL rmid_err_flags got=%0d exp=0", pq_cyc.size() + sq_cyc.size()); end
   endtask

   task automatic test_back_to_back;
      int         exp_vc[$];
      logic [7:0] exp_vd[$];
      int         exp_pc[$];
      int         e0, nv, np;
      logic [7:0] d;
      logic       pe, typ, bad, pb;
      clear_mon();
      for (int n = 0; n < 20; n++) begin
         d   = 8'($urandom);
         pe  = 1'($urandom);
         typ = 1'($urandom);
         bad = pe && ($urandom_range(0, 3) == 0);
         pb  = exp_par(d, typ) ^ bad;
         send_frame(d, pe, typ, pb, 1'b1, e0);
         if (bad) begin
            exp_pc.push_back(res_cyc(e0, pe));
         end else begin
            exp_vc.push_back(res_cyc(e0, pe));
            exp_vd.push_back(d);
         end
      end
      hold(2 * P);
      checks++; if (vq_cyc.size() != exp_vc.size()) begin failures++; $display("FAIL b2b_valid_count got=%0d exp=%0d", vq_cyc.size(), exp_vc.size()); end
      nv = (vq_cyc.size() < exp_vc.size()) ? vq_cyc.size() : exp_vc.size();
      for (int i = 0; i < nv; i++) begin
         checks++; if (vq_dat[i] !== exp_vd[i]) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, vq_dat[i], exp_vd[i]); end
         checks++; if (vq_cyc[i] != exp_vc[i]) begin failures++; $display("FAIL b2b_valid_edge[%0d] got=%0d exp=%0d", i, vq_cyc[i], exp_vc[i]); end
      end
      checks++; if (pq_cyc.size() != exp_pc.size()) begin failures++; $display("FAIL b2b_par_count got=%0d exp=%0d", pq_cyc.size(), exp_pc.size()); end
      np = (pq_cyc.size() < exp_pc.size()) ? pq_cyc.size() : exp_pc.size();
      for (int i = 0; i < np; i++) begin
         checks++; if (pq_cyc[i] != exp_pc[i]) begin failures++; $display("FAIL b2b_par_edge[%0d] got=%0d exp=%0d", i, pq_cyc[i], exp_pc[i]); end
      end
      checks++; if (sq_cyc.size() != 0) begin failures++; $display("FAIL b2b_stp_count got=%0d exp=0", sq_cyc.size()); end
      if (exp_vd.size() > 0) begin
         checks++; if (P_DATA !== exp_vd[exp_vd.size() - 1]) begin failures++; $display("FAIL b2b_last_pdata got=%h exp=%h", P_DATA, exp_vd[exp_vd.size() - 1]); end
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_basic();
      test_parity();
      test_break();
      test_glitch();
`ifdef UART_RX_MAJORITY_EN
      test_majority_glitch();
`endif
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
